// File: rtl/etapa_mem_wb_ext.sv
// -----------------------------------------------------------------------------
// etapa_mem_wb_ext
// MEM/WB pipeline register with debug stepping, stall/flush control, a sticky
// HALT latch and a saturating retired-instruction counter.
//
// Ports
//   i_clk, i_reset        clock; synchronous active-low reset
//   i_Step                debug enable, 0 freezes all state
//   i_Stall, i_Flush      hold contents / load a bubble (flush wins)
//   i_Valid               incoming MEM slot carries a real instruction
//   i_PC4, i_Instruction,
//   i_ALU, i_DatoMemoria  MEM-stage data (NBITS each)
//   i_RegistroDestino     destination register index (RNBITS)
//   i_MemToReg, i_RegWrite,
//   i_Halt                write-back controls, HALT marker
//   o_*                   registered copies of the above
//   o_WriteData           selected write-back value
//   o_RegWriteEff         register-file write enable actually used
//   o_Halt                sticky: a valid HALT has reached WB
//   o_Retired             saturating count of valid instructions loaded
//
// Handshake: there is no back-pressure. An instruction is accepted on any
// rising edge where reset is inactive, i_Step=1, o_Halt=0, i_Flush=0 and
// i_Stall=0; i_Valid qualifies it and becomes o_Valid one cycle later.
// -----------------------------------------------------------------------------
module etapa_mem_wb_ext #(
  parameter int NBITS   = 32,
  parameter int RNBITS  = 5,
  parameter int CNTBITS = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_Step,
  input  logic               i_Stall,
  input  logic               i_Flush,
  input  logic               i_Valid,
  input  logic [NBITS-1:0]   i_PC4,
  input  logic [NBITS-1:0]   i_Instruction,
  input  logic [NBITS-1:0]   i_ALU,
  input  logic [NBITS-1:0]   i_DatoMemoria,
  input  logic [RNBITS-1:0]  i_RegistroDestino,
  input  logic               i_MemToReg,
  input  logic               i_RegWrite,
  input  logic               i_Halt,
  output logic [NBITS-1:0]   o_PC4,
  output logic [NBITS-1:0]   o_Instruction,
  output logic [NBITS-1:0]   o_ALU,
  output logic [NBITS-1:0]   o_DatoMemoria,
  output logic [RNBITS-1:0]  o_RegistroDestino,
  output logic               o_MemToReg,
  output logic               o_RegWrite,
  output logic               o_Valid,
  output logic [NBITS-1:0]   o_WriteData,
  output logic               o_RegWriteEff,
  output logic               o_Halt,
  output logic [CNTBITS-1:0] o_Retired
);

  localparam logic [CNTBITS-1:0] CNT_MAX = {CNTBITS{1'b1}};
  localparam logic [CNTBITS-1:0] CNT_ONE = {{(CNTBITS-1){1'b0}}, 1'b1};

  logic [NBITS-1:0]   r_pc4;
  logic [NBITS-1:0]   r_instruction;
  logic [NBITS-1:0]   r_alu;
  logic [NBITS-1:0]   r_dato;
  logic [RNBITS-1:0]  r_rd;
  logic               r_memtoreg;
  logic               r_regwrite;
  logic               r_valid;
  logic               r_halt;
  logic [CNTBITS-1:0] r_retired;

  logic               w_load;
  logic [NBITS-1:0]   w_write_data;
  logic               w_regwrite_eff;

  // Stage may change only when stepping and not halted; halt freezes
  // everything including flush, only reset escapes it.
  logic w_active;
  assign w_active = i_Step && !r_halt;
  assign w_load   = w_active && !i_Flush && !i_Stall;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_pc4         <= '0;
      r_instruction <= '0;
      r_alu         <= '0;
      r_dato        <= '0;
      r_rd          <= '0;
      r_memtoreg    <= 1'b0;
      r_regwrite    <= 1'b0;
      r_valid       <= 1'b0;
      r_halt        <= 1'b0;
      r_retired     <= '0;
    end else if (w_active && i_Flush) begin
      // Bubble: counter is left untouched.
      r_pc4         <= '0;
      r_instruction <= '0;
      r_alu         <= '0;
      r_dato        <= '0;
      r_rd          <= '0;
      r_memtoreg    <= 1'b0;
      r_regwrite    <= 1'b0;
      r_valid       <= 1'b0;
    end else if (w_load) begin
      r_pc4         <= i_PC4;
      r_instruction <= i_Instruction;
      r_alu         <= i_ALU;
      r_dato        <= i_DatoMemoria;
      r_rd          <= i_RegistroDestino;
      r_memtoreg    <= i_MemToReg;
      r_regwrite    <= i_RegWrite;
      r_valid       <= i_Valid;
      if (i_Valid) begin
        // Saturate rather than wrap.
        if (r_retired != CNT_MAX) begin
          r_retired <= r_retired + CNT_ONE;
        end
        // The HALT instruction itself is captured and counted above.
        if (i_Halt) begin
          r_halt <= 1'b1;
        end
      end
    end
  end

  assign w_write_data   = r_memtoreg ? r_dato : r_alu;
  // Bubbles and writes to the hard-wired zero register never write.
  assign w_regwrite_eff = r_regwrite && r_valid && (r_rd != '0);

  assign o_PC4             = r_pc4;
  assign o_Instruction     = r_instruction;
  assign o_ALU             = r_alu;
  assign o_DatoMemoria     = r_dato;
  assign o_RegistroDestino = r_rd;
  assign o_MemToReg        = r_memtoreg;
  assign o_RegWrite        = r_regwrite;
  assign o_Valid           = r_valid;
  assign o_WriteData       = w_write_data;
  assign o_RegWriteEff     = w_regwrite_eff;
  assign o_Halt            = r_halt;
  assign o_Retired         = r_retired;

endmodule

// File: doc/etapa_mem_wb_ext.md
ETAPA_MEM_WB_EXT -- requirements
Module: etapa_mem_wb_ext

Interface
REQ-001 Parameter NBITS, default 32, data/instruction/PC width.
REQ-002 Parameter RNBITS, default 5, register-index width.
REQ-003 Parameter CNTBITS, default 16, retired-instruction counter width.
REQ-004 Port i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port i_reset  input  1  reset, synchronous and active-low.
REQ-006 Port i_Step  input  1  debug enable; 0 freezes all state.
REQ-007 Port i_Stall  input  1  hold current contents.
REQ-008 Port i_Flush  input  1  load a bubble.
REQ-009 Port i_Valid  input  1  incoming MEM-stage slot holds a real instruction.
REQ-010 Ports i_PC4, i_Instruction, i_ALU, i_DatoMemoria  input  NBITS each  MEM-stage data.
REQ-011 Port i_RegistroDestino  input  RNBITS  destination register index.
REQ-012 Ports i_MemToReg, i_RegWrite, i_Halt  input  1 each  WB controls; i_Halt marks a HALT instruction.
REQ-013 Ports o_PC4, o_Instruction, o_ALU, o_DatoMemoria  output  NBITS each  registered copies.
REQ-014 Ports o_RegistroDestino  output  RNBITS; o_MemToReg, o_RegWrite, o_Valid  output  1 each  registered copies.
REQ-015 Port o_WriteData  output  NBITS  o_DatoMemoria when o_MemToReg=1, else o_ALU (combinational from registers).
REQ-016 Port o_RegWriteEff  output  1  o_RegWrite AND o_Valid AND (o_RegistroDestino != 0).
REQ-017 Port o_Halt  output  1  sticky: a valid HALT has reached WB.
REQ-018 Port o_Retired  output  CNTBITS  count of valid instructions loaded into WB.

Function
REQ-019 Update priority per edge SHALL be: reset, then i_Step=0 (hold all), then o_Halt=1 (hold all), then i_Flush, then i_Stall, then load.
REQ-020 Load SHALL capture every input into its register; o_Valid <= i_Valid.
REQ-021 Flush SHALL clear all data, index and control registers to 0 and o_Valid to 0; o_Retired unchanged.
REQ-022 Stall SHALL hold every register, o_Valid and o_Retired unchanged.
REQ-023 i_Flush and i_Stall both high SHALL act as flush.
REQ-024 A load with i_Valid=1 SHALL increment o_Retired by 1; saturate at 2^CNTBITS-1, no wrap.
REQ-025 A load with i_Valid=0 SHALL not change o_Retired; control bits are captured but masked by o_Valid in o_RegWriteEff.
REQ-026 A load with i_Valid=1 and i_Halt=1 SHALL set o_Halt on that edge; the HALT instruction is itself captured and counted.
REQ-027 i_Halt with i_Valid=0, or on a stall/flush cycle, SHALL not set o_Halt.
REQ-028 Once set, o_Halt SHALL remain 1 and all registers frozen until reset, regardless of i_Step, i_Stall, i_Flush.
REQ-029 Latency: one cycle from a loading edge to outputs; o_WriteData and o_RegWriteEff valid in the same cycle as the registers.
REQ-030 Writes to register 0 SHALL never assert o_RegWriteEff.

Reset
REQ-031 While i_reset=0 at a rising edge, all data/index/control registers, o_Valid, o_Halt and o_Retired SHALL become 0, overriding every other input.
REQ-032 Reset SHALL be sampled only on i_clk edges; asserting it mid-stall or after halt SHALL still clear everything at the next edge.
REQ-033 After reset release, first edge with i_Step=1 and no stall/flush SHALL load normally.

Verification
REQ-034 Reset then load i_Valid=1, i_ALU=0x00000010, i_DatoMemoria=0xDEADBEEF, i_MemToReg=1, i_RegWrite=1, dest=5 -> next cycle o_WriteData=0xDEADBEEF, o_RegWriteEff=1, o_Retired=1.
REQ-035 Same load with dest=0 -> o_RegWriteEff=0, o_Retired=1; with i_Valid=0 -> o_RegWriteEff=0, o_Retired=0.
REQ-036 Load instruction A, then 3 cycles i_Stall=1 with different inputs -> outputs remain A, o_Retired=1; then i_Stall=1 and i_Flush=1 -> all outputs 0, o_Valid=0, o_Retired=1.
REQ-037 i_Step=0 for 4 cycles with changing valid inputs -> no output or counter change; i_Step=1 -> loads resume.
REQ-038 Load valid HALT -> o_Halt=1 next cycle, o_Retired incremented; 5 further valid loads -> outputs and o_Retired frozen; i_reset=0 one edge -> everything 0.
REQ-039 CNTBITS=4, 17 consecutive valid loads -> o_Retired stops at 15.
